// File: rtl/gon_ctrl.sv
// ============================================================================
// gon_ctrl : GON scan-chain programmer and multicast transfer sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module gon_ctrl #(
  parameter int ROW_TAG_WIDTH  = 4,
  parameter int COL_TAG_WIDTH  = 4,
  parameter int NUM_OF_ROWS    = 12,
  parameter int NUM_OF_COLS    = 14,
  parameter int CFG_WORD_WIDTH = 32,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic                      cfg_valid,
  input  logic [CFG_WORD_WIDTH-1:0] cfg_word,
  output logic                      cfg_ready,
  output logic                      cfg_done,
  input  logic                      req_valid,
  input  logic [ROW_TAG_WIDTH-1:0]  req_row_tag,
  input  logic [COL_TAG_WIDTH-1:0]  req_col_tag,
  input  logic [LEN_WIDTH-1:0]      req_len,
  output logic                      req_ready,
  output logic                      xfer_done,
  input  logic                      gon_ready,
  output logic [ROW_TAG_WIDTH-1:0]  row_tag,
  output logic [COL_TAG_WIDTH-1:0]  col_tag,
  output logic                      enable_in,
  output logic                      scan_en_id,
  output logic                      scan_in_id,
  output logic                      busy
);

  localparam int SCAN_LEN = NUM_OF_ROWS * (ROW_TAG_WIDTH + NUM_OF_COLS * COL_TAG_WIDTH);
  localparam int CNT_W    = $clog2(SCAN_LEN);
  localparam int BL_W     = $clog2(CFG_WORD_WIDTH + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;
  localparam logic [1:0] c_SEND = 2'd3;

  localparam logic [CNT_W-1:0] c_LAST_BIT  = CNT_W'(SCAN_LEN - 1);
  localparam logic [BL_W-1:0]  c_WORD_BITS = BL_W'(CFG_WORD_WIDTH);

  logic [1:0]                state_q, state_d;
  logic [CFG_WORD_WIDTH-1:0] word_q, word_d;
  logic [BL_W-1:0]           bits_q, bits_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [LEN_WIDTH-1:0]      beats_q, beats_d;
  logic [ROW_TAG_WIDTH-1:0]  row_q, row_d;
  logic [COL_TAG_WIDTH-1:0]  col_q, col_d;
  logic                      cfg_done_q, cfg_done_d;
  logic                      xfer_done_q, xfer_done_d;

  logic w_shift, w_last_bit, w_cfg_hs, w_req_hs, w_beat, w_last_beat, w_restart;

  // A request seen together with cfg_start is refused, so ready drops with it.
  assign w_restart   = ((state_q == c_IDLE) || (state_q == c_RUN)) && cfg_start;
  assign w_shift     = (state_q == c_SCAN) && (bits_q != '0);
  assign w_last_bit  = w_shift && (bit_cnt_q == c_LAST_BIT);
  assign w_cfg_hs    = cfg_valid && (state_q == c_SCAN) && (bits_q == '0);
  assign w_req_hs    = req_valid && (state_q == c_RUN) && !cfg_start;
  assign w_beat      = (state_q == c_SEND) && gon_ready && (beats_q != '0);
  assign w_last_beat = w_beat && (beats_q == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_IDLE;
      word_q      <= '0;
      bits_q      <= '0;
      bit_cnt_q   <= '0;
      beats_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cfg_done_q  <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bits_q      <= bits_d;
      bit_cnt_q   <= bit_cnt_d;
      beats_q     <= beats_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cfg_done_q  <= cfg_done_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (cfg_start) state_d = c_SCAN;
      c_SCAN:  if (w_last_bit) state_d = c_RUN;
      c_RUN: begin
        if (cfg_start)                        state_d = c_SCAN;
        else if (w_req_hs && req_len != '0)   state_d = c_SEND;
      end
      c_SEND:  if (w_last_beat) state_d = c_RUN;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    word_d      = word_q;
    bits_d      = bits_q;
    bit_cnt_d   = bit_cnt_q;
    beats_d     = beats_q;
    row_d       = row_q;
    col_d       = col_q;
    cfg_done_d  = 1'b0;
    xfer_done_d = 1'b0;

    if (w_restart) begin
      bit_cnt_d = '0;
      bits_d    = '0;
    end
    if (w_cfg_hs) begin
      word_d = cfg_word;
      bits_d = c_WORD_BITS;
    end
    if (w_shift) begin
      word_d    = word_q >> 1;
      bits_d    = bits_q - 1'b1;
      bit_cnt_d = bit_cnt_q + 1'b1;
      // Chain is full: whatever is left of the current word is dropped.
      if (w_last_bit) begin
        word_d     = '0;
        bits_d     = '0;
        bit_cnt_d  = '0;
        cfg_done_d = 1'b1;
      end
    end
    if (w_req_hs) begin
      row_d   = req_row_tag;
      col_d   = req_col_tag;
      beats_d = req_len;
      if (req_len == '0) xfer_done_d = 1'b1;
    end
    if (w_beat) begin
      beats_d = beats_q - 1'b1;
      if (w_last_beat) xfer_done_d = 1'b1;
    end
  end

  always_comb begin
    cfg_ready  = (state_q == c_SCAN) && (bits_q == '0);
    req_ready  = (state_q == c_RUN) && !cfg_start;
    enable_in  = w_beat;
    scan_en_id = w_shift;
    scan_in_id = word_q[0];
    busy       = (state_q == c_SCAN) || (state_q == c_SEND);
    row_tag    = row_q;
    col_tag    = col_q;
    cfg_done   = cfg_done_q;
    xfer_done  = xfer_done_q;
  end

endmodule

`default_nettype wire

// File: doc/gon_ctrl.md
# gon_ctrl

Sequencing controller for the global on-chip network (GON) multicast fabric of the PE array. It programs every row and column ID register through the GON scan chain from a stream of configuration words. It then serves transfer requests by driving `row_tag`/`col_tag` and metering `enable_in` beats against the fabric's aggregate `ready_out`. It sits between the global-buffer-side request logic and the GON instance.

## Interface
- `ROW_TAG_WIDTH`, 4, width of row tag / row ID
- `COL_TAG_WIDTH`, 4, width of column tag / column ID
- `NUM_OF_ROWS`, 12, PE array rows
- `NUM_OF_COLS`, 14, PE array columns
- `CFG_WORD_WIDTH`, 32, configuration word width
- `LEN_WIDTH`, 8, burst length field width
- Derived: `SCAN_LEN = NUM_OF_ROWS*(ROW_TAG_WIDTH + NUM_OF_COLS*COL_TAG_WIDTH)`, which is 720 at defaults.
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `cfg_start`  in  1  pulse; begins scan programming
- `cfg_valid`  in  1  configuration word valid
- `cfg_word`  in  CFG_WORD_WIDTH  configuration bits, LSB shifted first
- `cfg_ready`  out  1  controller accepts `cfg_word`
- `cfg_done`  out  1  one-cycle pulse when the last scan bit has been shifted
- `req_valid`  in  1  transfer request valid
- `req_row_tag`  in  ROW_TAG_WIDTH  destination row tag
- `req_col_tag`  in  COL_TAG_WIDTH  destination column tag
- `req_len`  in  LEN_WIDTH  number of beats
- `req_ready`  out  1  controller accepts a request
- `xfer_done`  out  1  one-cycle pulse when a request completes
- `gon_ready`  in  1  from GON `ready_out`
- `row_tag`  out  ROW_TAG_WIDTH  to GON
- `col_tag`  out  COL_TAG_WIDTH  to GON
- `enable_in`  out  1  to GON; one beat per high cycle
- `scan_en_id`  out  1  to GON scan enable
- `scan_in_id`  out  1  to GON scan data
- `busy`  out  1  state is not IDLE and not RUN

## Operation
- States: IDLE, SCAN, RUN, SEND.
- Reset values: state IDLE; all outputs 0, including tags, `scan_in_id` and all counters.
- **IDLE**
  - `cfg_start` moves the controller to SCAN.
  - Requests are not accepted.
- **SCAN**
  - `cfg_ready` is 1 only while the word shift register is empty.
  - On a `cfg_valid && cfg_ready` handshake, the word is loaded.
  - In each following cycle, one bit, starting at the LSB, is presented on `scan_in_id` with `scan_en_id`=1.
  - The bit counter counts 0..SCAN_LEN-1.
  - When no bit is pending, `scan_en_id`=0; a gap in words stalls the chain.
  - After bit SCAN_LEN-1:
    - the remaining bits of the current word are discarded;
    - `cfg_done` pulses in the following cycle;
    - the state becomes RUN.
  - Bit order: the first bit shifted ends in the farthest register of the chain, the column-0 row-0 ID position first downstream of the last xbus.
- **RUN**
  - `req_ready`=1.
  - On a handshake, the tags and length are latched and the state becomes SEND.
  - `req_len`=0 completes immediately: `xfer_done` pulses the next cycle and the state stays RUN.
  - `cfg_start` in RUN re-enters SCAN and resets the bit counter; it takes priority over a simultaneous request, which is not accepted.
- **SEND**
  - `row_tag`/`col_tag` are held at the latched values.
  - `enable_in = gon_ready && (beats_left != 0)` (combinational from `gon_ready`).
  - Each high cycle decrements `beats_left`.
  - When the final beat issues, `xfer_done` pulses the next cycle and the state returns to RUN.
  - `cfg_start` and `cfg_valid` are ignored in SEND.
- Tag outputs keep their last values outside SEND; they are cleared only by reset.
- Reset mid-SCAN or mid-SEND returns to IDLE next edge, with no further `enable_in` or `scan_en_id`. The partially programmed chain contents are not guaranteed.

## Timing
- Scan throughput: one word per CFG_WORD_WIDTH+1 cycles (accept cycle plus W shift cycles).
- Full configuration at defaults:
  - 23 words, 720 shift cycles;
  - `cfg_done` one cycle after the last `scan_en_id` high cycle.
- Request-to-first-beat: a handshake at edge N puts the state in SEND from N+1, so `enable_in` can be high in cycle N+1 if `gon_ready`=1.
- With `gon_ready` held at 1, an L-beat request gives L consecutive `enable_in` cycles.
- `gon_ready` low stalls without losing beats.
- Back-to-back: next `req_ready` is in the cycle after the last beat (one bubble).
- `cfg_done` and `xfer_done` are registered single-cycle pulses.

## Test plan
- **Reset:** assert `reset` 3 cycles with random inputs -> all outputs 0 and state IDLE; `req_valid`=1 is not accepted.
- **Full scan:** `cfg_start`, then feed 23 words 0xA5A5A5A5 with no gaps -> exactly 720 `scan_en_id` cycles, the `scan_in_id` sequence is 1,0,1,0,0,1,0,1…, the last 16 bits of word 23 are never driven, `cfg_done` pulses once, and `req_ready` rises.
- **Stalled scan:** insert 5-cycle `cfg_valid` gaps -> `scan_en_id` is low during the gaps and the bit count still totals 720.
- **Burst with backpressure:** request row=3, col=7, len=4; `gon_ready` pattern 1,0,0,1,1,0,1 -> `enable_in` mirrors the 1s for exactly 4 beats, tags are 3/7 throughout, and `xfer_done` pulses after beat 4.
- **Edge lengths:** `req_len`=0 -> no `enable_in`, `xfer_done` next cycle. `req_len`=255 with `gon_ready`=1 -> 255 contiguous beats.
- **Priority and reset:** `cfg_start` together with `req_valid` in RUN -> SCAN, request not accepted. Reset asserted at beat 2 of len=6 -> `enable_in` is 0 from the next cycle and the state is IDLE.
